// File: rtl/argmin_signed_stream.sv
// -----------------------------------------------------------------------------
// argmin_signed_stream
//   Streaming signed arg-min finder. Scans a frame of COUNT two's-complement
//   scores and reports the smallest value together with its position. Ties
//   keep the earliest index. Used for nearest-prototype selection (smallest
//   distance) in the classification stage.
//
//   Ports
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     clear      in   1      synchronous abort, current frame discarded
//     in_valid   in   1      in_data is valid
//     in_ready   out  1      block can accept in_data (registered)
//     in_data    in   SIZE   signed score
//     out_valid  out  1      result is valid
//     out_ready  in   1      downstream takes the result
//     out_value  out  SIZE   minimum score of the frame
//     out_index  out  IDX_W  position (0..COUNT-1) of the minimum
// -----------------------------------------------------------------------------

// Signed a >= b on SIZE-bit two's-complement operands. Both operands are
// sign-extended by one bit so the difference can never overflow.
module greater_than_signed_lookahead #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  output logic            o_ge
);

  logic signed [SIZE:0] w_a;
  logic signed [SIZE:0] w_b;
  logic signed [SIZE:0] w_diff;

  assign w_a    = {i_a[SIZE-1], i_a};
  assign w_b    = {i_b[SIZE-1], i_b};
  assign w_diff = w_a - w_b;
  assign o_ge   = ~w_diff[SIZE];

endmodule

module argmin_signed_stream #(
  parameter int SIZE  = 8,
  parameter int COUNT = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_value,
  output logic [IDX_W-1:0] out_index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [SIZE-1:0]  r_out_value;
  logic [IDX_W-1:0] r_out_index;
  logic [SIZE-1:0]  r_best_val;
  logic [IDX_W-1:0] r_best_idx;

  logic             w_xfer;
  logic             w_ge;
  logic             w_take;
  logic             w_last;
  logic [SIZE-1:0]  w_next_val;
  logic [IDX_W-1:0] w_next_idx;

  assign w_xfer = in_valid && r_in_ready;
  assign w_last = (r_count == LAST);

  greater_than_signed_lookahead #(
    .SIZE (SIZE)
  ) u_cmp (
    .i_a  (in_data),
    .i_b  (r_best_val),
    .o_ge (w_ge)
  );

  // Replace only on strictly less, so the earliest minimum wins a tie.
  assign w_take     = ~w_ge;
  assign w_next_val = w_take ? in_data : r_best_val;
  assign w_next_idx = w_take ? r_count : r_best_idx;

  // Running best: pure datapath, reloaded by element 0 of every frame.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      if (r_state == IDLE) begin
        r_best_val <= in_data;
        r_best_idx <= '0;
      end else begin
        r_best_val <= w_next_val;
        r_best_idx <= w_next_idx;
      end
    end
  end

  // Control FSM with registered handshake outputs. in_ready comes up on the
  // first edge after reset and is dropped on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_index <= '0;
    end else if (clear) begin
      // Abort wins over any handshake; last result stays on the outputs.
      r_state     <= IDLE;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_count <= IDX_W'(1);
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_xfer) begin
            if (w_last) begin
              // Final comparison folds straight into the output registers.
              r_out_value <= w_next_val;
              r_out_index <= w_next_idx;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= DONE;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign out_index = r_out_index;

endmodule

// File: tb/tb_argmin_signed_stream.sv
module tb_argmin_signed_stream;

  localparam int SIZE  = 8;
  localparam int COUNT = 10;
  localparam int IDX_W = 4;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_value;
  logic [IDX_W-1:0] out_index;

  argmin_signed_stream #(
    .SIZE  (SIZE),
    .COUNT (COUNT),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d [COUNT];
    int ev;
    int ei;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one element and let it transfer on the next posedge.
  task automatic push(input int d);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = SIZE'(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic feed(input int v, input bit gaps, input int n_elem);
    for (int i = 0; i < n_elem; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) @(negedge clk);
      end
      push(vecs[v].d[i]);
    end
  endtask

  // Called on the negedge right after the last transfer: checks 1-clk latency.
  task automatic check_result(input string tag, input int v);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_value"}, int'($signed(out_value)), vecs[v].ev);
    chk({tag, "_index"}, int'(out_index), vecs[v].ei);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_popped"}, int'(out_valid), 0);
    chk({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].d = '{5, 3, 9, -2, 7, 0, 1, 4, 8, 6};
    vecs[0].ev = -2;   vecs[0].ei = 3;
    vecs[1].d = '{4, 4, 1, 1, 4, 1, 9, 9, 9, 9};
    vecs[1].ev = 1;    vecs[1].ei = 2;
    vecs[2].d = '{127, -128, 0, 0, 0, 0, 0, 0, 0, -128};
    vecs[2].ev = -128; vecs[2].ei = 1;
    vecs[3].d = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    vecs[3].ev = 7;    vecs[3].ei = 0;
    vecs[4].d = '{10, 9, 8, 7, 6, 5, 4, 3, 2, -100};
    vecs[4].ev = -100; vecs[4].ei = 9;
    vecs[5].d = '{-128, 127, -1, 0, 1, -127, 127, 126, -2, 3};
    vecs[5].ev = -128; vecs[5].ei = 0;
    vecs[6].d = '{-1, -1, -1, -1, -1, -7, -1, -1, -1, -1};
    vecs[6].ev = -7;   vecs[6].ei = 5;

    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_value", int'(out_value), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_in_ready",  int'(in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Table-driven frames with immediate pop
    for (int v = 0; v < 6; v++) begin
      feed(v, 1'b0, COUNT);
      check_result($sformatf("vec%0d", v), v);
      pop($sformatf("vec%0d", v));
    end

    // Backpressure: hold result, ignore extra input, then next frame is clean
    out_ready = 1'b0;
    feed(0, 1'b0, COUNT);
    check_result("bp", 0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 8'h80;
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_value", int'($signed(out_value)), -2);
      chk("bp_hold_index", int'(out_index), 3);
      chk("bp_in_ready",   int'(in_ready), 0);
    end
    in_valid = 1'b0;
    pop("bp");
    feed(1, 1'b0, COUNT);
    check_result("bp_next", 1);
    pop("bp_next");

    // Frame with random in_valid gaps
    feed(6, 1'b1, COUNT);
    check_result("gaps", 6);
    pop("gaps");

    // clear after 4 elements; transfer in the clear cycle is discarded
    feed(4, 1'b0, 4);
    in_valid = 1'b1;
    in_data  = 8'h80;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_in_ready",  int'(in_ready), 1);
    chk("clr_hold_value", int'($signed(out_value)), -7);
    chk("clr_hold_index", int'(out_index), 5);
    feed(0, 1'b0, COUNT);
    check_result("clr_next", 0);
    pop("clr_next");

    // clear in DONE beats the output handshake and keeps the result
    out_ready = 1'b0;
    feed(3, 1'b0, COUNT);
    check_result("clr_done", 3);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_done_valid", int'(out_valid), 0);
    chk("clr_done_rdy",   int'(in_ready), 1);
    chk("clr_done_value", int'($signed(out_value)), 7);
    chk("clr_done_index", int'(out_index), 0);

    // Prime a nonzero result, then reset mid-frame asynchronously
    feed(4, 1'b0, COUNT);
    check_result("pre_rst", 4);
    pop("pre_rst");
    feed(0, 1'b0, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_value", int'(out_value), 0);
    chk("arst_out_index", int'(out_index), 0);
    chk("arst_in_ready",  int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_rdy_back", int'(in_ready), 1);
    feed(2, 1'b0, COUNT);
    check_result("post_arst", 2);
    pop("post_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
